// File: rtl/regfile_fault_sequencer_pkg.sv
// regfile_fault_sequencer_pkg: shared command codes, request record and FSM states for the fault sequencer.
package regfile_fault_sequencer_pkg;

    localparam int COMMAND_WIDTH = 2;
    localparam logic [COMMAND_WIDTH-1:0] CMD_NOP  = 2'd0;
    localparam logic [COMMAND_WIDTH-1:0] CMD_FLIP = 2'd1;
    localparam logic [COMMAND_WIDTH-1:0] CMD_MARK = 2'd2;

    localparam int DEF_BIT_W   = 6;
    localparam int DEF_DELAY_W = 16;

    typedef struct packed {
        logic [4:0]             reg_idx;
        logic [DEF_BIT_W-1:0]   bit_idx;
        logic [DEF_DELAY_W-1:0] delay;
        logic                   mark;
    } fault_req_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_MARK,
        S_GUARD
    } fault_seq_state_e;

endpackage

// File: rtl/fault_req_fifo.sv
// fault_req_fifo: DEPTH-entry request queue; pointers carry an extra MSB to tell full from empty.
module fault_req_fifo
    import regfile_fault_sequencer_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fault_req_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  T                       wdata,
    output T                       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wr;
    logic [AW:0] rd;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push && !full) wr <= wr + (AW+1)'(1);
            if (pop && !empty) rd <= rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr[AW-1:0]] <= wdata;
    end

    assign level = wr - rd;
    assign full  = level == (AW+1)'(DEPTH);
    assign empty = wr == rd;
    assign rdata = mem[rd[AW-1:0]];

endmodule

// File: rtl/regfile_fault_sequencer.sv
// regfile_fault_sequencer: releases queued FLIP (and optional MARK) pulses to the register file
// after a programmable delay, with forced guard gaps between commands.
module regfile_fault_sequencer
    import regfile_fault_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 4,
    parameter int DELAY_WIDTH  = 16,
    parameter int GUARD_CYCLES = 1,
    localparam int BIT_W       = $clog2(DATA_WIDTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [4:0]               req_reg_i,
    input  logic [BIT_W-1:0]         req_bit_i,
    input  logic [DELAY_WIDTH-1:0]   req_delay_i,
    input  logic                     req_mark_i,
    output logic                     cmd_valid_o,
    output logic [COMMAND_WIDTH-1:0] cmd_command_o,
    output logic [4:0]               cmd_data0_o,
    output logic [BIT_W-1:0]         cmd_data1_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [15:0]              issued_cnt_o
);

    localparam int GW = $clog2(GUARD_CYCLES) + 1;

    typedef struct packed {
        logic [4:0]             reg_idx;
        logic [BIT_W-1:0]       bit_idx;
        logic [DELAY_WIDTH-1:0] delay;
        logic                   mark;
    } req_t;

    fault_seq_state_e       state;
    fault_seq_state_e       nxt;
    req_t                   head;
    req_t                   work;
    logic [DELAY_WIDTH-1:0] cnt;
    logic [GW-1:0]          g;
    logic                   full;
    logic                   empty;
    logic                   pop;

    assign req_ready_o = !full && !flush_i;
    assign pop         = state == S_IDLE && !empty && enable_i && !flush_i;
    assign busy_o      = state != S_IDLE || !empty;

    fault_req_fifo #(.DEPTH(DEPTH), .T(req_t)) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (req_valid_i && req_ready_o),
        .pop   (pop),
        .flush (flush_i),
        .wdata ('{reg_idx: req_reg_i, bit_idx: req_bit_i, delay: req_delay_i, mark: req_mark_i}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            work         <= '0;
            cnt          <= '0;
            g            <= '0;
            issued_cnt_o <= '0;
        end else begin
            state <= nxt;
            if (pop) begin
                work <= head;
                cnt  <= head.delay - DELAY_WIDTH'(1);
            end else if (state == S_WAIT && enable_i && cnt != '0) begin
                cnt <= cnt - DELAY_WIDTH'(1);
            end
            // Reloaded everywhere outside GUARD so it is primed on entry.
            g <= state == S_GUARD ? g - GW'(1) : GW'(GUARD_CYCLES - 1);
            if (state == S_ISSUE && issued_cnt_o != 16'hFFFF) issued_cnt_o <= issued_cnt_o + 16'd1;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = pop ? (head.delay == '0 ? S_ISSUE : S_WAIT) : S_IDLE;
            S_WAIT:  nxt = flush_i ? S_IDLE : (enable_i && cnt == '0) ? S_ISSUE : S_WAIT;
            S_ISSUE: nxt = (work.mark && !flush_i) ? S_MARK : S_GUARD;
            S_MARK:  nxt = flush_i ? S_IDLE : S_GUARD;
            S_GUARD: nxt = g == '0 ? S_IDLE : S_GUARD;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid_o   = state == S_ISSUE || state == S_MARK;
        cmd_command_o = state == S_ISSUE ? CMD_FLIP : state == S_MARK ? CMD_MARK : CMD_NOP;
        cmd_data0_o   = state == S_ISSUE ? work.reg_idx : '0;
        cmd_data1_o   = state == S_ISSUE ? work.bit_idx : '0;
    end

endmodule

// File: tb/tb_regfile_fault_sequencer.sv
// tb_regfile_fault_sequencer: directed stimulus with a pulse scoreboard checked by a separate monitor.
module tb_regfile_fault_sequencer;
    import regfile_fault_sequencer_pkg::*;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        enable = 1;
    logic        flush = 0;
    logic        req_valid = 0;
    logic        req_ready;
    logic [4:0]  req_reg = 0;
    logic [5:0]  req_bit = 0;
    logic [15:0] req_delay = 0;
    logic        req_mark = 0;
    logic        cmd_valid;
    logic [1:0]  cmd_command;
    logic [4:0]  cmd_data0;
    logic [5:0]  cmd_data1;
    logic        busy;
    logic [2:0]  level;
    logic [15:0] issued_cnt;

    regfile_fault_sequencer dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .flush_i       (flush),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_reg_i     (req_reg),
        .req_bit_i     (req_bit),
        .req_delay_i   (req_delay),
        .req_mark_i    (req_mark),
        .cmd_valid_o   (cmd_valid),
        .cmd_command_o (cmd_command),
        .cmd_data0_o   (cmd_data0),
        .cmd_data1_o   (cmd_data1),
        .busy_o        (busy),
        .level_o       (level),
        .issued_cnt_o  (issued_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] cmd;
        logic [4:0] d0;
        logic [5:0] d1;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_m;
    int   checks = 0;
    int   errors = 0;
    int   t;
    int   e;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int c, input logic [1:0] cmd, input logic [4:0] d0, input logic [5:0] d1);
        exp_q.push_back('{cyc: c, cmd: cmd, d0: d0, d1: d1});
    endtask

    task automatic push(input logic [4:0] r, input logic [5:0] b, input logic [15:0] d, input logic m);
        req_valid = 1;
        req_reg   = r;
        req_bit   = b;
        req_delay = d;
        req_mark  = m;
        step();
        req_valid = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n && cmd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got cmd %0d d0 %0d d1 %0d at cycle %0d, expected no pulse",
                         cmd_command, cmd_data0, cmd_data1, cyc);
            end else begin
                e_m = exp_q.pop_front();
                chk("pulse_cycle", cyc, e_m.cyc);
                chk("pulse_cmd", cmd_command, e_m.cmd);
                chk("pulse_data0", cmd_data0, e_m.d0);
                chk("pulse_data1", cmd_data1, e_m.d1);
            end
        end
    end

    initial begin
        repeat (3) step();
        rst_n = 1;
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd", cmd_command, CMD_NOP);
        chk("rst_data0", cmd_data0, 0);
        chk("rst_data1", cmd_data1, 0);
        chk("rst_issued", issued_cnt, 0);

        // zero delay: FLIP two cycles after the push
        t = cyc;
        expect_pulse(t + 2, CMD_FLIP, 5, 3);
        push(5, 3, 0, 0);
        repeat (6) step();
        chk("t1_issued", issued_cnt, 1);
        chk("t1_busy", busy, 0);

        // delay 10 with MARK
        t = cyc;
        expect_pulse(t + 12, CMD_FLIP, 7, 63);
        expect_pulse(t + 13, CMD_MARK, 0, 0);
        push(7, 63, 10, 1);
        repeat (16) step();
        chk("t2_issued", issued_cnt, 2);

        // fill with enable low, fifth push refused, then drain in order
        enable = 0;
        for (int i = 1; i <= 4; i++) push(5'(i), 6'(i + 9), 0, 0);
        chk("t3_ready_full", req_ready, 0);
        chk("t3_level_full", level, 4);
        push(9, 9, 0, 0);
        chk("t3_level_after_refused", level, 4);
        e = cyc;
        for (int i = 1; i <= 4; i++) expect_pulse(e + 1 + 3 * (i - 1), CMD_FLIP, 5'(i), 6'(i + 9));
        enable = 1;
        repeat (14) step();
        chk("t3_level_drained", level, 0);
        chk("t3_issued", issued_cnt, 6);
        chk("t3_busy", busy, 0);

        // delay 20 with enable low for 6 cycles during WAIT
        t = cyc;
        expect_pulse(t + 28, CMD_FLIP, 2, 17);
        push(2, 17, 20, 0);
        repeat (5) step();
        enable = 0;
        repeat (6) step();
        enable = 1;
        repeat (25) step();
        chk("t4_issued", issued_cnt, 7);

        // flush during WAIT with two queued requests and a simultaneous push
        push(3, 4, 50, 0);
        push(4, 5, 0, 0);
        push(6, 7, 0, 1);
        chk("t5_level_queued", level, 2);
        flush = 1;
        req_valid = 1;
        req_reg = 9;
        #1;
        chk("t5_ready_flush", req_ready, 0);
        step();
        flush = 0;
        req_valid = 0;
        chk("t5_level_flushed", level, 0);
        chk("t5_busy_flushed", busy, 0);
        repeat (60) step();
        chk("t5_issued", issued_cnt, 7);
        chk("t5_level_end", level, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
